lut_gate_classifier: RTL and testbench
======================================

// Module: lut_gate_classifier
// PURPOSE
//   Sequential inverse of the gate-to-LUT mapping: accepts a $lut truth table plus its active width and
//   classifies it back to a primitive gate ($_NOT_/$_AND_/$_OR_/$_XOR_/$_MUX_), a buffer, or a constant.
//   Also reports which LUT inputs the function depends on. Used by the on-chip netlist-audit engine
//   to re-derive gate-level structure from LUT-mapped logic.
// PARAMETERS
//   LUT_WIDTH   4   max LUT inputs supported; table is 2**LUT_WIDTH bits
//   WBITS       $clog2(LUT_WIDTH+1)   width of IN_WIDTH (derived, do not override)
// PORTS
//   CLK          in   1              sole clock, rising edge
//   ARST_N       in   1              asynchronous active-low reset
//   IN_VALID     in   1              request valid
//   IN_READY     out  1              block can accept request (high only in IDLE)
//   IN_LUT       in   2**LUT_WIDTH   truth table, bit i = output for input vector i (A = bit 0 of i)
//   IN_WIDTH     in   WBITS          active inputs W; table bits >= 2**W ignored
//   OUT_VALID    out  1              result valid
//   OUT_READY    in   1              consumer accepts result
//   OUT_KIND     out  4              gate code (see package)
//   OUT_SUPPORT  out  LUT_WIDTH      bit k set = output depends on input k
// BEHAVIOUR
//   Reset: state IDLE, IN_READY=1, OUT_VALID=0, OUT_KIND=KIND_UNKNOWN, OUT_SUPPORT=0; async assert, sync release.
//   FSM IDLE -> SCAN -> COMPACT -> DONE -> IDLE.
//   IDLE: on IN_VALID&IN_READY (cycle 0) latch IN_LUT masked to 2**W bits, latch W, clear support; -> SCAN.
//     If IN_WIDTH > LUT_WIDTH: skip to DONE with KIND_UNKNOWN, support 0 (DONE at cycle 1).
//   SCAN: one table index i per cycle, i = 0..N-1, N = 2**W. For each k < W: support[k] |= T[i] ^ T[i ^ (1<<k)].
//     W=0: N=1, support stays 0.
//   COMPACT: ns = popcount(support). If ns > 3: M=0, result KIND_UNKNOWN. Else M = 2**ns cycles; cycle j
//     writes R[j] = T[scatter(j)], scatter places bit b of j onto the b-th lowest set support index (others 0).
//   Classify R (combinational at end of COMPACT, registered into outputs):
//     ns=0: R=0 -> CONST0, R=1 -> CONST1. ns=1: 2'b10 BUF, 2'b01 NOT.
//     ns=2: 4'b1000 AND, 4'b1110 OR, 4'b0110 XOR. ns=3: 8'b1100_1010 MUX (A,B,S = ascending support idx).
//     Any other R -> KIND_UNKNOWN (inverted forms, e.g. NAND, are UNKNOWN by design).
//   DONE: OUT_VALID=1 from cycle 1+N+M; OUT_KIND/OUT_SUPPORT stable while OUT_VALID&!OUT_READY.
//     OUT_VALID&OUT_READY -> IDLE next cycle; OUT_VALID drops, IN_READY rises same edge. No overlap of jobs.
//   IN_READY=0 in SCAN/COMPACT/DONE; IN_VALID ignored there. Inputs IN_LUT/IN_WIDTH sampled only at accept.
//   ARST_N low in any state: immediate return to reset values; partial job discarded, no output produced.
//   Index arithmetic: counter LUT_WIDTH+1 bits, terminates at N-1 / M-1 exactly; no wrap past table.
// STRUCTURE
//   Shared include lut_gate_kinds.vh (`define codes, reused by audit software model):
//     KIND_CONST0=0, CONST1=1, BUF=2, NOT=3, AND=4, OR=5, XOR=6, MUX=7, UNKNOWN=15;
//     canonical tables TBL_NOT=2'b01, TBL_AND=4'b1000, TBL_OR=4'b1110, TBL_XOR=4'b0110, TBL_MUX=8'hCA.
//   One sub-module: lut_support_scatter (combinational: support mask + j -> table index); rest in top FSM.
// TESTING
//   1. W=2, IN_LUT=16'h0008, OUT_READY=1 -> OUT_KIND=AND, SUPPORT=4'b0011, OUT_VALID at cycle 9 (1+4+4).
//   2. W=4, IN_LUT=16'hA0A0 -> OUT_KIND=AND, SUPPORT=4'b0101 (inputs 1,3 unused), OUT_VALID at cycle 21.
//   3. W=3, IN_LUT=16'hFFCA (upper bits garbage) -> MUX, SUPPORT=4'b0111; W=1, IN_LUT=16'hFFF1 -> NOT, 4'b0001.
//   4. W=4, IN_LUT=16'h6996 -> UNKNOWN, SUPPORT=4'b1111, OUT_VALID at cycle 17 (M=0); W=2, 16'h0007 -> UNKNOWN.
//   5. Hold OUT_READY=0 10 cycles after result: OUT_VALID/KIND/SUPPORT stable, IN_READY=0, new IN_VALID ignored.
//   6. ARST_N pulsed low mid-SCAN: OUT_VALID=0, IN_READY=1 asynchronously; next job W=0, IN_LUT=1 -> CONST1.

Source files
------------

// File: rtl/lut_gate_classifier_pkg.sv
// Shared types for the LUT-to-gate classifier: FSM states, gate kind codes,
// canonical truth tables, and popcount/classify helpers.
package lut_gate_classifier_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_COMPACT,
    S_DONE
  } state_e;

  typedef enum logic [3:0] {
    KIND_CONST0  = 4'd0,
    KIND_CONST1  = 4'd1,
    KIND_BUF     = 4'd2,
    KIND_NOT     = 4'd3,
    KIND_AND     = 4'd4,
    KIND_OR      = 4'd5,
    KIND_XOR     = 4'd6,
    KIND_MUX     = 4'd7,
    KIND_UNKNOWN = 4'd15
  } kind_e;

  localparam logic [1:0] TBL_BUF = 2'b10;
  localparam logic [1:0] TBL_NOT = 2'b01;
  localparam logic [3:0] TBL_AND = 4'b1000;
  localparam logic [3:0] TBL_OR  = 4'b1110;
  localparam logic [3:0] TBL_XOR = 4'b0110;
  localparam logic [7:0] TBL_MUX = 8'hCA;

  function automatic int popcount(logic [31:0] v);
    int n;
    n = 0;
    for (int b = 0; b < 32; b++) begin
      n = n + int'(v[b]);
    end
    return n;
  endfunction

  // r holds the compacted table: bit j is the output for the
  // j-th assignment of the supporting inputs (lowest index = bit 0).
  function automatic kind_e classify(int ns, logic [7:0] r);
    kind_e k;
    k = KIND_UNKNOWN;
    unique case (ns)
      0: k = r[0] ? KIND_CONST1 : KIND_CONST0;
      1: begin
        if (r[1:0] == TBL_BUF) k = KIND_BUF;
        else if (r[1:0] == TBL_NOT) k = KIND_NOT;
      end
      2: begin
        if (r[3:0] == TBL_AND) k = KIND_AND;
        else if (r[3:0] == TBL_OR) k = KIND_OR;
        else if (r[3:0] == TBL_XOR) k = KIND_XOR;
      end
      3: if (r == TBL_MUX) k = KIND_MUX;
      default: k = KIND_UNKNOWN;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/lut_support_scatter.sv
// Maps a compacted index onto a full table index: bit b of sel lands on the
// b-th lowest set bit of support; unsupported positions are 0.
// Ports: support (mask), sel (compact index) -> index (table index).
module lut_support_scatter #(
  parameter int LUT_WIDTH = 4
) (
  input  logic [LUT_WIDTH-1:0] support,
  input  logic [LUT_WIDTH-1:0] sel,
  output logic [LUT_WIDTH-1:0] index
);

  always_comb begin
    int b;
    b = 0;
    index = '0;
    for (int k = 0; k < LUT_WIDTH; k++) begin
      if (support[k]) begin
        index[k] = sel[b];
        b = b + 1;
      end
    end
  end

endmodule

// File: rtl/lut_gate_classifier.sv
// Classifies a LUT truth table back to a primitive gate, buffer or constant.
// Ports: IN_* request (valid/ready), OUT_* result (valid/ready, kind, support).
module lut_gate_classifier
  import lut_gate_classifier_pkg::*;
#(
  parameter int LUT_WIDTH = 4,
  parameter int WBITS     = $clog2(LUT_WIDTH + 1)
) (
  input  logic                      CLK,
  input  logic                      ARST_N,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [2**LUT_WIDTH-1:0]   IN_LUT,
  input  logic [WBITS-1:0]          IN_WIDTH,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [3:0]                OUT_KIND,
  output logic [LUT_WIDTH-1:0]      OUT_SUPPORT
);

  localparam int TW = 2**LUT_WIDTH;
  localparam int CW = LUT_WIDTH + 1;

  state_e               state_q, state_d;
  logic [CW-1:0]        idx_q, idx_d;
  logic [TW-1:0]        tbl_q, tbl_d;
  logic [WBITS-1:0]     width_q, width_d;
  logic [LUT_WIDTH-1:0] support_q, support_d;
  logic [7:0]           res_q, res_d;
  kind_e                kind_q, kind_d;

  logic [LUT_WIDTH-1:0] scat_idx;
  logic [LUT_WIDTH-1:0] scan_sup;
  logic [LUT_WIDTH-1:0] cur;
  logic [TW-1:0]        lut_mask;
  logic [CW-1:0]        n_last;
  logic [CW-1:0]        m_last;
  int                   ns;

  lut_support_scatter #(
    .LUT_WIDTH(LUT_WIDTH)
  ) u_scatter (
    .support(support_q),
    .sel    (idx_q[LUT_WIDTH-1:0]),
    .index  (scat_idx)
  );

  assign IN_READY    = (state_q == S_IDLE);
  assign OUT_VALID   = (state_q == S_DONE);
  assign OUT_KIND    = kind_q;
  assign OUT_SUPPORT = support_q;

  always_comb begin
    cur      = idx_q[LUT_WIDTH-1:0];
    n_last   = (CW'(1) << width_q) - CW'(1);
    ns       = popcount(32'(support_q));
    m_last   = (CW'(1) << ns) - CW'(1);
    lut_mask = '0;
    for (int b = 0; b < TW; b++) begin
      lut_mask[b] = (b < (1 << int'(IN_WIDTH)));
    end
    // A pair of entries differing only in input k that disagree
    // proves the output depends on k.
    scan_sup = support_q;
    for (int k = 0; k < LUT_WIDTH; k++) begin
      if (k < int'(width_q)) begin
        scan_sup[k] = scan_sup[k] |
          (tbl_q[cur] ^ tbl_q[cur ^ (LUT_WIDTH'(1) << k)]);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tbl_d     = tbl_q;
    width_d   = width_q;
    support_d = support_q;
    res_d     = res_q;
    kind_d    = kind_q;
    unique case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          width_d   = IN_WIDTH;
          support_d = '0;
          idx_d     = '0;
          res_d     = '0;
          if (int'(IN_WIDTH) > LUT_WIDTH) begin
            tbl_d   = '0;
            kind_d  = KIND_UNKNOWN;
            state_d = S_DONE;
          end else begin
            tbl_d   = IN_LUT & lut_mask;
            state_d = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        support_d = scan_sup;
        if (idx_q == n_last) begin
          idx_d = '0;
          // More than three inputs cannot be any known gate:
          // skip compaction entirely.
          if (popcount(32'(scan_sup)) > 3) begin
            kind_d  = KIND_UNKNOWN;
            state_d = S_DONE;
          end else begin
            state_d = S_COMPACT;
          end
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      S_COMPACT: begin
        res_d[idx_q[2:0]] = tbl_q[scat_idx];
        if (idx_q == m_last) begin
          idx_d   = '0;
          kind_d  = classify(ns, res_d);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      S_DONE: begin
        if (OUT_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      tbl_q     <= '0;
      width_q   <= '0;
      support_q <= '0;
      res_q     <= '0;
      kind_q    <= KIND_UNKNOWN;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tbl_q     <= tbl_d;
      width_q   <= width_d;
      support_q <= support_d;
      res_q     <= res_d;
      kind_q    <= kind_d;
    end
  end

endmodule

// File: tb/tb_lut_gate_classifier.sv
// Scoreboard bench for lut_gate_classifier: directed jobs push expectations,
// a monitor pops and compares kind, support and latency on each handshake.
module tb_lut_gate_classifier;

  logic        CLK;
  logic        ARST_N;
  logic        IN_VALID;
  logic        IN_READY;
  logic [15:0] IN_LUT;
  logic [2:0]  IN_WIDTH;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [3:0]  OUT_KIND;
  logic [3:0]  OUT_SUPPORT;

  typedef struct {
    string      name;
    logic [3:0] kind;
    logic [3:0] sup;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc = 0;
  int   lat = 0;
  bit   seen = 0;

  lut_gate_classifier dut (
    .CLK        (CLK),
    .ARST_N     (ARST_N),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .IN_LUT     (IN_LUT),
    .IN_WIDTH   (IN_WIDTH),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .OUT_KIND   (OUT_KIND),
    .OUT_SUPPORT(OUT_SUPPORT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Monitor: latency counts negedges from the accept edge (cycle 0).
  always @(negedge CLK) begin
    exp_t e;
    cyc++;
    if (!ARST_N) begin
      seen = 0;
    end else begin
      if (IN_VALID && IN_READY) acc = cyc;
      if (OUT_VALID && !seen) begin
        seen = 1;
        lat  = cyc - acc;
      end
      if (OUT_VALID && OUT_READY) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: kind %0d with empty scoreboard",
                   OUT_KIND);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_kind"}, int'(OUT_KIND), int'(e.kind));
          chk({e.name, "_support"}, int'(OUT_SUPPORT), int'(e.sup));
          chk({e.name, "_latency"}, lat, e.lat);
        end
        seen = 0;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(string name, logic [15:0] lut, logic [2:0] w,
                      logic [3:0] kind, logic [3:0] sup, int l, bit push);
    exp_t e;
    int n;
    n = 0;
    while (!IN_READY && n < 200) begin
      tick();
      n++;
    end
    if (!IN_READY) begin
      chk({name, "_ready_timeout"}, 0, 1);
      return;
    end
    IN_LUT   = lut;
    IN_WIDTH = w;
    IN_VALID = 1'b1;
    if (push) begin
      e.name = name;
      e.kind = kind;
      e.sup  = sup;
      e.lat  = l;
      sb.push_back(e);
    end
    tick();
    IN_VALID = 1'b0;
    IN_LUT   = 16'h0000;
    IN_WIDTH = 3'd0;
  endtask

  task automatic drain(string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    if (sb.size() != 0) chk({name, "_drain_timeout"}, sb.size(), 0);
  endtask

  initial begin
    int n;
    IN_VALID  = 1'b0;
    IN_LUT    = 16'h0000;
    IN_WIDTH  = 3'd0;
    OUT_READY = 1'b1;
    ARST_N    = 1'b0;
    #12;
    chk("reset_in_ready", int'(IN_READY), 1);
    chk("reset_out_valid", int'(OUT_VALID), 0);
    chk("reset_kind", int'(OUT_KIND), 15);
    chk("reset_support", int'(OUT_SUPPORT), 0);
    tick();
    ARST_N = 1'b1;
    tick();

    send("and_w2",   16'h0008, 3'd2, 4'd4,  4'b0011, 9,  1);
    drain("and_w2");
    send("and_w4",   16'hA0A0, 3'd4, 4'd4,  4'b0101, 21, 1);
    drain("and_w4");
    send("mux_w3",   16'hFFCA, 3'd3, 4'd7,  4'b0111, 17, 1);
    send("not_w1",   16'hFFF1, 3'd1, 4'd3,  4'b0001, 5,  1);
    send("xor4_w4",  16'h6996, 3'd4, 4'd15, 4'b1111, 17, 1);
    send("nand_w2",  16'h0007, 3'd2, 4'd15, 4'b0011, 9,  1);
    send("or_w2",    16'hFFFE, 3'd2, 4'd5,  4'b0011, 9,  1);
    send("xor_w2",   16'h0006, 3'd2, 4'd6,  4'b0011, 9,  1);
    send("buf_hi",   16'hCCCC, 3'd4, 4'd2,  4'b0010, 19, 1);
    send("const0",   16'hFF00, 3'd3, 4'd0,  4'b0000, 10, 1);
    send("bad_width",16'h0008, 3'd5, 4'd15, 4'b0000, 1,  1);
    drain("batch");

    // Back-pressure: result must hold and new requests be refused.
    OUT_READY = 1'b0;
    send("hold_and", 16'h0008, 3'd2, 4'd4, 4'b0011, 9, 1);
    n = 0;
    while (!OUT_VALID && n < 100) begin
      tick();
      n++;
    end
    chk("hold_reached_valid", int'(OUT_VALID), 1);
    IN_VALID = 1'b1;
    IN_LUT   = 16'h6996;
    IN_WIDTH = 3'd4;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("hold_out_valid", int'(OUT_VALID), 1);
      chk("hold_kind", int'(OUT_KIND), 4);
      chk("hold_support", int'(OUT_SUPPORT), 3);
      chk("hold_in_ready", int'(IN_READY), 0);
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    drain("hold");
    tick();
    chk("after_hold_in_ready", int'(IN_READY), 1);
    chk("after_hold_out_valid", int'(OUT_VALID), 0);

    // Async reset mid-scan discards the job (nothing pushed for it).
    send("aborted", 16'hA0A0, 3'd4, 4'd4, 4'b0101, 21, 0);
    repeat (5) tick();
    chk("midscan_in_ready", int'(IN_READY), 0);
    #2;
    ARST_N = 1'b0;
    #1;
    chk("arst_out_valid", int'(OUT_VALID), 0);
    chk("arst_in_ready", int'(IN_READY), 1);
    chk("arst_kind", int'(OUT_KIND), 15);
    chk("arst_support", int'(OUT_SUPPORT), 0);
    tick();
    ARST_N = 1'b1;
    tick();
    send("const1_w0", 16'h0001, 3'd0, 4'd1, 4'b0000, 3, 1);
    drain("const1");
    repeat (30) tick();
    chk("final_scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
